// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: ALU request, LSU handshake and the registered
// register-file write port. The arbiter takes the slave side.
interface wb_port_arbiter_if;
    logic        alu_write_req;
    logic [4:0]  alu_write_addr;
    logic [31:0] alu_write_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    modport master (
        output alu_write_req, alu_write_addr, alu_write_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  alu_stall, lsu_ready,
        input  rf_write_en, rf_write_addr, rf_write_data
    );

    modport slave (
        input  alu_write_req, alu_write_addr, alu_write_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output alu_stall, lsu_ready,
        output rf_write_en, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The ALU has priority; LSU results queue
// in a small FIFO and bypass it when nothing else wants the port. A wait
// counter on the FIFO head stalls the ALU so that queued loads retire.
// Queued loads overwritten by a younger ALU write are killed but still pop.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    wb_port_arbiter_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]            q_addr [FIFO_DEPTH];
    logic [31:0]           q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_kill;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [WW-1:0]         wait_cnt;

    logic full, nonempty, starve;
    logic gnt_fifo, gnt_alu, gnt_byp, push, pop, alu_kill;
    logic [FIFO_DEPTH-1:0] kill_hit;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign nonempty  = (count != '0);
    assign starve    = nonempty && (wait_cnt == WW'(MAX_WAIT));

    assign bus.lsu_ready = !full;
    assign bus.alu_stall = starve && bus.alu_write_req;

    // Exactly one (or no) source owns the port each cycle.
    assign gnt_fifo = starve || (!bus.alu_write_req && nonempty);
    assign gnt_alu  = !starve && bus.alu_write_req;
    assign gnt_byp  = !starve && !bus.alu_write_req && !nonempty && bus.lsu_valid;
    assign pop      = gnt_fifo;
    assign push     = bus.lsu_valid && !full && !gnt_byp;
    assign alu_kill = gnt_alu && (bus.alu_write_addr != 5'd0);

    // Live entries whose destination the granted ALU write supersedes.
    always_comb begin
        kill_hit = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_kill && ({1'b0, PW'(i) - rd_ptr} < count) &&
                (q_addr[i] == bus.alu_write_addr))
                kill_hit[i] = 1'b1;
        end
    end

    // FIFO storage, pointers, occupancy and head wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            q_kill   <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            q_kill <= q_kill | kill_hit;
            if (push) begin
                q_addr[wr_ptr] <= bus.lsu_addr;
                q_data[wr_ptr] <= bus.lsu_data;
                // An entry pushed alongside a same-rd ALU write is already stale.
                q_kill[wr_ptr] <= alu_kill && (bus.lsu_addr == bus.alu_write_addr);
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (pop || !nonempty)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered write port; address/data hold when nobody is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_write_en   <= 1'b0;
            bus.rf_write_addr <= '0;
            bus.rf_write_data <= '0;
        end else if (gnt_fifo) begin
            bus.rf_write_en   <= (q_addr[rd_ptr] != 5'd0) && !q_kill[rd_ptr];
            bus.rf_write_addr <= q_addr[rd_ptr];
            bus.rf_write_data <= q_data[rd_ptr];
        end else if (gnt_alu) begin
            bus.rf_write_en   <= (bus.alu_write_addr != 5'd0);
            bus.rf_write_addr <= bus.alu_write_addr;
            bus.rf_write_data <= bus.alu_write_data;
        end else if (gnt_byp) begin
            bus.rf_write_en   <= (bus.lsu_addr != 5'd0);
            bus.rf_write_addr <= bus.lsu_addr;
            bus.rf_write_data <= bus.lsu_data;
        end else begin
            bus.rf_write_en   <= 1'b0;
        end
    end
endmodule
